cpu_sequencer: RTL and testbench

//  Fetch/execute control stage directly upstream of the ALU: holds PC, IR' and the

---
 rtl/cpu_sequencer.sv | 156 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer feeding the ALU: PC, IR', CARRY/SKIP and the memory port.
// Optional wait-state support via SEQ_MEM_WAIT_EN (undefined: single-cycle memory).
module cpu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic [15:0] rd_rdata,
  input  logic [15:0] rs_rdata,
  output logic [15:0] instruction,
  output logic        exec1,
  output logic        exec2,
  output logic        carrystatus,
  output logic        skipstatus,
  input  logic        carryout,
  input  logic        carryen,
  input  logic        skipout,
  input  logic        skipen,
  output logic        ld_wen,
  output logic [15:0] ld_data
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC1 = 2'b01,
    ST_EXEC2 = 2'b10
  } state_t;

  localparam logic [1:0] OP_LDR = 2'b00;
  localparam logic [1:0] OP_STR = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_ALU = 2'b11;

  state_t      state_r;
  logic [15:0] pc_r;
  logic [15:0] ir_r;
  logic        carry_r;
  logic        skip_r;
  logic        exec1_r;
  logic        exec2_r;
  logic        mem_re_r;
  logic        mem_we_r;
  logic        ready_s;

  // Jump keeps the page (top nibble) of the already-incremented PC.
  function automatic logic [15:0] jmp_target(input logic [15:0] pc, input logic [15:0] ir);
    return {pc[15:12], ir[11:0]};
  endfunction

`ifdef SEQ_MEM_WAIT_EN
  assign ready_s = mem_ready;
`else
  logic unused_mem_ready_s;
  assign unused_mem_ready_s = mem_ready;
  assign ready_s            = 1'b1;
`endif

  // Sequencer state, architectural registers and registered strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_FETCH;
      pc_r     <= RESET_PC;
      ir_r     <= 16'h0000;
      carry_r  <= 1'b0;
      skip_r   <= 1'b0;
      exec1_r  <= 1'b0;
      exec2_r  <= 1'b0;
      mem_re_r <= 1'b1;
      mem_we_r <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (ready_s) begin
            ir_r     <= mem_rdata;
            pc_r     <= pc_r + 16'h0001;
            state_r  <= ST_EXEC1;
            exec1_r  <= ~skip_r;
            mem_re_r <= 1'b0;
          end
        end
        ST_EXEC1: begin
          exec1_r <= 1'b0;
          if (!exec1_r) begin
            // Squashed slot: only clears SKIP, so a skip can never chain.
            skip_r   <= 1'b0;
            state_r  <= ST_FETCH;
            mem_re_r <= 1'b1;
          end else begin
            if (carryen) carry_r <= carryout;
            if (skipen)  skip_r  <= skipout;
            case (ir_r[15:14])
              OP_ALU: begin
                state_r  <= ST_FETCH;
                mem_re_r <= 1'b1;
              end
              OP_JMP: begin
                pc_r     <= jmp_target(pc_r, ir_r);
                state_r  <= ST_FETCH;
                mem_re_r <= 1'b1;
              end
              OP_LDR: begin
                state_r  <= ST_EXEC2;
                exec2_r  <= 1'b1;
                mem_re_r <= 1'b1;
              end
              OP_STR: begin
                state_r  <= ST_EXEC2;
                exec2_r  <= 1'b1;
                mem_we_r <= 1'b1;
              end
              default: begin
                state_r  <= ST_FETCH;
                mem_re_r <= 1'b1;
              end
            endcase
          end
        end
        ST_EXEC2: begin
          if (ready_s) begin
            state_r  <= ST_FETCH;
            exec2_r  <= 1'b0;
            mem_re_r <= 1'b1;
            mem_we_r <= 1'b0;
          end
        end
        default: begin
          state_r  <= ST_FETCH;
          exec1_r  <= 1'b0;
          exec2_r  <= 1'b0;
          mem_re_r <= 1'b1;
          mem_we_r <= 1'b0;
        end
      endcase
    end
  end

  // The FETCH read request is held in reset so it can start on the first cycle after release.
  assign mem_re      = mem_re_r & ~reset;
  assign mem_we      = mem_we_r;
  assign mem_addr    = exec2_r ? rs_rdata : pc_r;
  assign mem_wdata   = rd_rdata;
  assign instruction = ir_r;
  assign exec1       = exec1_r;
  assign exec2       = exec2_r;
  assign carrystatus = carry_r;
  assign skipstatus  = skip_r;
  assign ld_wen      = exec2_r & mem_re_r & ready_s;
  assign ld_data     = mem_rdata;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: reset, ALU/JMP/skip flow, LDR/STR, PC wrap, reset mid-store.
module tb_cpu_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] rd_rdata;
  logic [15:0] rs_rdata;
  logic [15:0] instruction;
  logic        exec1;
  logic        exec2;
  logic        carrystatus;
  logic        skipstatus;
  logic        carryout;
  logic        carryen;
  logic        skipout;
  logic        skipen;
  logic        ld_wen;
  logic [15:0] ld_data;

  logic [15:0] w_mem_addr;
  logic [15:0] w_rdata;
  logic        unused_w_re, unused_w_we, unused_w_e1, unused_w_e2, unused_w_cs, unused_w_ss, unused_w_ldw;
  logic [15:0] unused_w_wdata, unused_w_ins, unused_w_ldd;

  logic [15:0] mem [0:65535];
  int n_checks;
  int n_fail;

  assign mem_rdata = mem_ready ? mem[mem_addr] : 16'h0000;
  assign w_rdata   = mem[w_mem_addr];

  cpu_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rd_rdata(rd_rdata), .rs_rdata(rs_rdata), .instruction(instruction),
    .exec1(exec1), .exec2(exec2), .carrystatus(carrystatus), .skipstatus(skipstatus),
    .carryout(carryout), .carryen(carryen), .skipout(skipout), .skipen(skipen),
    .ld_wen(ld_wen), .ld_data(ld_data)
  );

  // Second instance starting at the top of memory to observe PC wrap.
  cpu_sequencer #(.RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .reset(reset), .mem_addr(w_mem_addr), .mem_re(unused_w_re), .mem_we(unused_w_we),
    .mem_wdata(unused_w_wdata), .mem_rdata(w_rdata), .mem_ready(1'b1),
    .rd_rdata(rd_rdata), .rs_rdata(rs_rdata), .instruction(unused_w_ins),
    .exec1(unused_w_e1), .exec2(unused_w_e2), .carrystatus(unused_w_cs), .skipstatus(unused_w_ss),
    .carryout(carryout), .carryen(carryen), .skipout(skipout), .skipen(skipen),
    .ld_wen(unused_w_ldw), .ld_data(unused_w_ldd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    mem_ready = 1'b1;
    rd_rdata  = 16'h0000;
    rs_rdata  = 16'h0000;
    carryout  = 1'b0;
    carryen   = 1'b0;
    skipout   = 1'b0;
    skipen    = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'hC000;
    mem[16'h0004] = 16'h8FFD;
    mem[16'h1000] = 16'h8005;
    mem[16'h1005] = 16'h8123;
    mem[16'h1123] = 16'h0000;
    mem[16'h0040] = 16'hBEEF;
    mem[16'h1124] = 16'h4000;

    repeat (2) cyc;
    check("rst_re",    {15'h0, mem_re}, 16'h0000);
    check("rst_we",    {15'h0, mem_we}, 16'h0000);
    check("rst_exec1", {15'h0, exec1}, 16'h0000);
    check("rst_exec2", {15'h0, exec2}, 16'h0000);
    check("rst_ldwen", {15'h0, ld_wen}, 16'h0000);
    check("rst_ir",    instruction, 16'h0000);
    check("rst_flags", {14'h0, carrystatus, skipstatus}, 16'h0000);

    reset = 1'b0;
    #1;
    check("f0_re",   {15'h0, mem_re}, 16'h0001);
    check("f0_addr", mem_addr, 16'h0000);
    check("f0_exec1", {15'h0, exec1}, 16'h0000);
    check("wrap_f0", w_mem_addr, 16'hFFFF);

    cyc;
    check("e0_exec1", {15'h0, exec1}, 16'h0001);
    check("e0_ir",    instruction, 16'hC000);
    check("e0_strb",  {14'h0, mem_re, mem_we}, 16'h0000);
    carryen = 1'b1; carryout = 1'b1;
    cyc;
    check("f1_addr",  mem_addr, 16'h0001);
    check("f1_exec1", {15'h0, exec1}, 16'h0000);
    check("f1_carry", {15'h0, carrystatus}, 16'h0001);
    check("wrap_f1",  w_mem_addr, 16'h0000);
    carryen = 1'b0; carryout = 1'b0;
    cyc;
    check("e1_exec1", {15'h0, exec1}, 16'h0001);
    cyc;
    check("f2_addr",  mem_addr, 16'h0002);
    check("f2_carry", {15'h0, carrystatus}, 16'h0001);
    cyc;
    check("e2_exec1", {15'h0, exec1}, 16'h0001);
    skipen = 1'b1; skipout = 1'b1;
    cyc;
    check("f3_addr", mem_addr, 16'h0003);
    check("f3_skip", {15'h0, skipstatus}, 16'h0001);
    skipen = 1'b0; skipout = 1'b0;
    cyc;
    check("sq_exec1", {15'h0, exec1}, 16'h0000);
    check("sq_re",    {15'h0, mem_re}, 16'h0000);
    // A squashed slot must ignore ALU carry/skip updates.
    carryen = 1'b1; carryout = 1'b0; skipen = 1'b1; skipout = 1'b1;
    cyc;
    check("f4_addr",  mem_addr, 16'h0004);
    check("f4_skip",  {15'h0, skipstatus}, 16'h0000);
    check("f4_carry", {15'h0, carrystatus}, 16'h0001);
    carryen = 1'b0; skipen = 1'b0; skipout = 1'b0;
    cyc;
    check("e4_jmp_ir", instruction, 16'h8FFD);
    cyc;
    check("j_ffd", mem_addr, 16'h0FFD);
    repeat (2) cyc;
    check("j_ffe", mem_addr, 16'h0FFE);
    repeat (2) cyc;
    check("j_fff", mem_addr, 16'h0FFF);
    repeat (2) cyc;
    check("j_1000", mem_addr, 16'h1000);
    repeat (2) cyc;
    check("j_1005", mem_addr, 16'h1005);
    cyc;
    check("e1005_exec1", {15'h0, exec1}, 16'h0001);
    check("e1005_ir",    instruction, 16'h8123);
    cyc;
    check("j_1123", mem_addr, 16'h1123);

    rs_rdata = 16'h0040;
    cyc;
    check("ldr_e1",     {14'h0, exec1, exec2}, 16'h0002);
    check("ldr_e1_re",  {15'h0, mem_re}, 16'h0000);
`ifdef SEQ_MEM_WAIT_EN
    mem_ready = 1'b0;
    cyc;
    for (int w = 0; w < 3; w++) begin
      check("ldr_wait_exec2", {15'h0, exec2}, 16'h0001);
      check("ldr_wait_ldwen", {15'h0, ld_wen}, 16'h0000);
      check("ldr_wait_addr",  mem_addr, 16'h0040);
      cyc;
    end
    mem_ready = 1'b1;
    #1;
`else
    cyc;
`endif
    check("ldr_exec2", {15'h0, exec2}, 16'h0001);
    check("ldr_strb",  {14'h0, mem_re, mem_we}, 16'h0002);
    check("ldr_addr",  mem_addr, 16'h0040);
    check("ldr_ldwen", {15'h0, ld_wen}, 16'h0001);
    check("ldr_data",  ld_data, 16'hBEEF);
    cyc;
    check("f1124_addr",  mem_addr, 16'h1124);
    check("f1124_ldwen", {15'h0, ld_wen}, 16'h0000);
    check("f1124_exec2", {15'h0, exec2}, 16'h0000);

    rd_rdata = 16'hA5A5;
    rs_rdata = 16'h0080;
    cyc;
    check("str_e1", {15'h0, exec1}, 16'h0001);
`ifdef SEQ_MEM_WAIT_EN
    mem_ready = 1'b0;
`endif
    cyc;
    check("str_exec2", {15'h0, exec2}, 16'h0001);
    check("str_strb",  {14'h0, mem_re, mem_we}, 16'h0001);
    check("str_addr",  mem_addr, 16'h0080);
    check("str_wdata", mem_wdata, 16'hA5A5);
    check("str_ldwen", {15'h0, ld_wen}, 16'h0000);
    reset = 1'b1;
    #1;
    check("rst_mid_we",    {15'h0, mem_we}, 16'h0000);
    check("rst_mid_re",    {15'h0, mem_re}, 16'h0000);
    check("rst_mid_exec2", {15'h0, exec2}, 16'h0000);
    mem_ready = 1'b1;
    repeat (2) cyc;
    reset = 1'b0;
    #1;
    check("rel_addr",  mem_addr, 16'h0000);
    check("rel_re",    {15'h0, mem_re}, 16'h0001);
    check("rel_we",    {15'h0, mem_we}, 16'h0000);
    check("rel_flags", {14'h0, carrystatus, skipstatus}, 16'h0000);
    cyc;
    check("rel_exec1", {15'h0, exec1}, 16'h0001);
    check("rel_ir",    instruction, 16'hC000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
